// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
//   state_t         : converter FSM states (idle / shifting)
//   BCD_DIGIT_MAX   : largest legal BCD digit
//   BCD_CORR_THRESH : digit value at or above which the correction applies
//   BCD_CORR_SUB    : amount removed from a digit by the correction
package bcd_conv_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StShift
   } state_t;

   localparam logic [3:0] BCD_DIGIT_MAX   = 4'd9;
   localparam logic [3:0] BCD_CORR_THRESH = 4'd8;
   localparam logic [3:0] BCD_CORR_SUB    = 4'd3;

   function automatic logic digit_invalid(input logic [3:0] d);
      return d > BCD_DIGIT_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_correct.sv
// Reverse double-dabble digit correction: after a right shift a BCD digit
// that reads 8 or more has received a "ten" from the digit above, which
// as a binary half is worth 5, not 8, so 3 is taken off.
// Ports:
//   i_digit : 4-bit digit after the shift
//   o_digit : corrected digit
module bcd_digit_correct
   import bcd_conv_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= BCD_CORR_THRESH) ? (i_digit - BCD_CORR_SUB) : i_digit;

endmodule

// File: rtl/sequential_bcd_to_b_converter.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit
// per clock. A conversion takes BIN_W shift cycles; done pulses one cycle
// after the last shift, at which point the FSM is already idle again.
// Optional feature: define BCD_DIGIT_CHECK_EN to reject inputs containing
// a digit above 9 (done + err with bin_out = 0, no conversion started).
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous, active-high reset
//   start   : conversion request, sampled only while idle
//   bcd_in  : packed BCD input, digit 0 in [3:0]
//   busy    : conversion in progress
//   done    : one-cycle pulse when bin_out/err update
//   bin_out : converted value, held until the next done
//   err     : invalid-digit flag, held until the next done
module sequential_bcd_to_b_converter
   import bcd_conv_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int unsigned BcdW = 4 * DIGITS;
   localparam int unsigned CntW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(BIN_W - 1);

   state_t            r_state;
   logic [BcdW-1:0]   r_bcd;
   logic [BIN_W-1:0]  r_bin;
   logic [CntW-1:0]   r_cnt;
   logic              r_busy;
   logic              r_done;
   logic [BIN_W-1:0]  r_bin_out;
   logic              r_err;

   logic [BcdW-1:0]   w_bcd_shift;
   logic [BcdW-1:0]   w_bcd_corr;
   logic [BIN_W-1:0]  w_bin_shift;
   logic              w_bad;

   // The whole {bcd, bin} register shifts right; the bcd LSB enters the bin MSB.
   assign w_bcd_shift = {1'b0, r_bcd[BcdW-1:1]};
   assign w_bin_shift = {r_bcd[0], r_bin[BIN_W-1:1]};

   for (genvar g = 0; g < DIGITS; g++) begin : g_corr
      bcd_digit_correct u_corr (
         .i_digit (w_bcd_shift[4*g +: 4]),
         .o_digit (w_bcd_corr[4*g +: 4])
      );
   end

`ifdef BCD_DIGIT_CHECK_EN
   always_comb begin
      w_bad = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (digit_invalid(bcd_in[4*i +: 4])) w_bad = 1'b1;
      end
   end
`else
   assign w_bad = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= StIdle;
         r_bcd     <= '0;
         r_bin     <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_bin_out <= '0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (start && w_bad) begin
                  // Rejected input: report immediately, stay idle.
                  r_done    <= 1'b1;
                  r_err     <= 1'b1;
                  r_bin_out <= '0;
               end else if (start) begin
                  r_bcd   <= bcd_in;
                  r_bin   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= StShift;
               end
            end
            StShift: begin
               r_bcd <= w_bcd_corr;
               r_bin <= w_bin_shift;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CntLast) begin
                  r_bin_out <= w_bin_shift;
                  r_err     <= 1'b0;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign bin_out = r_bin_out;
   assign err     = r_err;

endmodule

// File: tb/tb_sequential_bcd_to_b_converter.sv
// Self-checking bench for sequential_bcd_to_b_converter (DIGITS=4, BIN_W=14).
// A cycle-level behavioural model computes the decimal value of each
// accepted BCD word arithmetically and predicts busy/done/bin_out/err;
// a compare process checks the DUT against it every cycle. Directed tests
// add literal expectations for latency and specific values.
module tb_sequential_bcd_to_b_converter;

   localparam int DIGITS = 4;
   localparam int BIN_W  = 14;
`ifdef BCD_DIGIT_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [15:0]       bcd_in = '0;
   logic              busy;
   logic              done;
   logic [BIN_W-1:0]  bin_out;
   logic              err;

   int total = 0;
   int bad   = 0;

   sequential_bcd_to_b_converter #(
      .DIGITS (DIGITS),
      .BIN_W  (BIN_W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int bcd_value(input logic [15:0] b);
      int v = 0;
      for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
      return v;
   endfunction

   function automatic bit bcd_has_bad(input logic [15:0] b);
      for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] b = '0;
      int t = v;
      for (int i = 0; i < DIGITS; i++) begin
         b[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return b;
   endfunction

   // ---------------- behavioural model ----------------
   int  m_rem = 0;   // shift cycles still to run
   int  m_pend = 0;
   int  m_bin = 0;
   bit  m_done = 0;
   bit  m_err = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_rem  <= 0;
         m_pend <= 0;
         m_bin  <= 0;
         m_done <= 1'b0;
         m_err  <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_rem == 0) begin
            if (start) begin
               if (CHECK && bcd_has_bad(bcd_in)) begin
                  m_done <= 1'b1;
                  m_err  <= 1'b1;
                  m_bin  <= 0;
               end else begin
                  m_rem  <= BIN_W;
                  m_pend <= bcd_value(bcd_in) % (1 << BIN_W);
               end
            end
         end else if (m_rem == 1) begin
            m_rem  <= 0;
            m_done <= 1'b1;
            m_bin  <= m_pend;
            m_err  <= 1'b0;
         end else begin
            m_rem <= m_rem - 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      #1;
      chk("cyc_busy", int'(busy), int'(m_rem != 0));
      chk("cyc_done", int'(done), int'(m_done));
      chk("cyc_bin_out", int'(bin_out), m_bin);
      chk("cyc_err", int'(err), int'(m_err));
      if (busy && done) chk("busy_and_done", 1, 0);
   end

   // Call right after a negedge; returns at the negedge of the done cycle.
   task automatic run_conv(input logic [15:0] b, output int lat, output int busy_cnt);
      start    = 1'b1;
      bcd_in   = b;
      lat      = -1;
      busy_cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            lat = k;
            break;
         end
      end
      if (lat < 0) chk("done_timeout", lat, 15);
   endtask

   int lat, bc, dcnt;

   initial begin
      // reset state
      #2;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_bin_out", int'(bin_out), 0);
      chk("rst_err", int'(err), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 1234: latency and busy window
      run_conv(16'h1234, lat, bc);
      chk("t1_latency", lat, 15);
      chk("t1_busy_cycles", bc, 14);
      chk("t1_bin_out", int'(bin_out), 1234);
      chk("t1_err", int'(err), 0);

      // 9999 then 0000 back to back, started in the done cycle
      run_conv(16'h9999, lat, bc);
      chk("t2a_bin_out", int'(bin_out), 9999);
      chk("t2a_latency", lat, 15);
      run_conv(16'h0000, lat, bc);
      chk("t2b_latency", lat, 15);
      chk("t2b_bin_out", int'(bin_out), 0);

      // 0042 with an ignored start in cycle 5
      repeat (2) @(negedge clk);
      start  = 1'b1;
      bcd_in = 16'h0042;
      dcnt   = 0;
      lat    = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = (k == 5);
         if (k == 5) bcd_in = 16'h0777;
         if (done) begin
            dcnt++;
            if (lat < 0) lat = k;
         end
      end
      chk("t3_done_count", dcnt, 1);
      chk("t3_latency", lat, 15);
      chk("t3_bin_out", int'(bin_out), 42);

      // 5678 interrupted by reset in cycle 7
      start  = 1'b1;
      bcd_in = 16'h5678;
      dcnt   = 0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) dcnt++;
      end
      reset = 1'b1;
      #1;
      chk("t4_rst_busy", int'(busy), 0);
      chk("t4_rst_done", int'(done), 0);
      chk("t4_rst_bin_out", int'(bin_out), 0);
      chk("t4_rst_err", int'(err), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("t4_no_done", dcnt, 0);
      run_conv(16'h0001, lat, bc);
      chk("t4_bin_out", int'(bin_out), 1);
      chk("t4_latency", lat, 15);

`ifdef BCD_DIGIT_CHECK_EN
      // invalid digit rejected
      run_conv(16'h12A4, lat, bc);
      chk("t5_latency", lat, 1);
      chk("t5_err", int'(err), 1);
      chk("t5_bin_out", int'(bin_out), 0);
      chk("t5_busy_cycles", bc, 0);
      run_conv(16'h0010, lat, bc);
      chk("t5b_err", int'(err), 0);
      chk("t5b_bin_out", int'(bin_out), 10);
`endif

      // back-to-back sweep over a spread of values (model checks every cycle)
      for (int v = 0; v <= 9999; v += 7) begin
         run_conv(to_bcd(v), lat, bc);
         chk("sweep_bin_out", int'(bin_out), v);
      end
      run_conv(to_bcd(8765), lat, bc);
      chk("sweep_8765", int'(bin_out), 8765);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
